// File: rtl/merge22_buf.sv
// merge22_buf: packs 22 discrete input bits into an OUT_W-bit word and buffers it in a 2-entry FIFO.
// Optional macro MERGE22_PARITY_EN adds a per-entry even-parity bit presented on OUT_PAR.
module merge22_buf #(
    parameter int OUT_W    = 16,
    parameter int SATURATE = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             D0,
    input  logic             D1,
    input  logic             D2,
    input  logic             D3,
    input  logic             D4,
    input  logic             D5,
    input  logic             D6,
    input  logic             D7,
    input  logic             D8,
    input  logic             D9,
    input  logic             D10,
    input  logic             D11,
    input  logic             D12,
    input  logic             D13,
    input  logic             D14,
    input  logic             D15,
    input  logic             D16,
    input  logic             D17,
    input  logic             D18,
    input  logic             D19,
    input  logic             D20,
    input  logic             D21,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [OUT_W-1:0] OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
`ifdef MERGE22_PARITY_EN
    output logic             OUT_PAR,
`endif
    output logic             OVF,
    input  logic             OVF_CLR
);

    localparam int DEPTH = 2;

    logic [21:0]      d_bus;
    logic             lost;
    logic [OUT_W-1:0] packed_word;
    logic [OUT_W-1:0] store_word;

    logic [OUT_W-1:0] mem [DEPTH];
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             in_ready_q;
    logic             ovf_q;
    logic             accept;
    logic             release_word;

    assign d_bus = {D21, D20, D19, D18, D17, D16, D15, D14, D13, D12, D11,
                    D10, D9,  D8,  D7,  D6,  D5,  D4,  D3,  D2,  D1,  D0};

    assign packed_word = d_bus[OUT_W-1:0];

    // The upper slice only exists when the bus is narrower than the input word.
    generate
        if (OUT_W < 22) begin : g_lost
            assign lost = |d_bus[21:OUT_W];
        end else begin : g_no_lost
            assign lost = 1'b0;
        end
    endgenerate

    always_comb begin
        store_word = packed_word;
        if ((SATURATE != 0) && lost) begin
            store_word = '1;
        end
    end

    assign accept       = IN_VALID & in_ready_q;
    assign release_word = OUT_VALID & OUT_READY;

    always_comb begin
        count_next = count;
        case ({accept, release_word})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            in_ready_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            count      <= count_next;
            in_ready_q <= (count_next < 2'(DEPTH));
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (release_word) begin
                rd_ptr <= ~rd_ptr;
            end
            if (accept && lost) begin
                ovf_q <= 1'b1;
            end else if (OVF_CLR) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // NOTE: the storage array is not reset; an entry is only read while it
    // holds a written word, and the empty-FIFO output is forced to zero below.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[wr_ptr] <= store_word;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = (count != 2'd0);
    assign OUT       = OUT_VALID ? mem[rd_ptr] : '0;
    assign OVF       = ovf_q;

`ifdef MERGE22_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (accept) begin
            par_mem[wr_ptr] <= ^store_word;
        end
    end

    assign OUT_PAR = OUT_VALID ? par_mem[rd_ptr] : 1'b0;
`endif

endmodule

// File: tb/tb_merge22_buf.sv
// Directed bench for merge22_buf: a truncating and a saturating instance share one stimulus stream.
module tb_merge22_buf;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [21:0] d;
    logic        IN_VALID;
    logic        OUT_READY;
    logic        OVF_CLR;

    logic        in_ready_t, out_valid_t, ovf_t;
    logic [15:0] out_t;
    logic        in_ready_s, out_valid_s, ovf_s;
    logic [15:0] out_s;
`ifdef MERGE22_PARITY_EN
    logic        out_par_t, out_par_s;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    merge22_buf #(.OUT_W(16), .SATURATE(0)) dut_trunc (
        .CLK(CLK), .RESET(RESET),
        .D0(d[0]),   .D1(d[1]),   .D2(d[2]),   .D3(d[3]),   .D4(d[4]),   .D5(d[5]),
        .D6(d[6]),   .D7(d[7]),   .D8(d[8]),   .D9(d[9]),   .D10(d[10]), .D11(d[11]),
        .D12(d[12]), .D13(d[13]), .D14(d[14]), .D15(d[15]), .D16(d[16]), .D17(d[17]),
        .D18(d[18]), .D19(d[19]), .D20(d[20]), .D21(d[21]),
        .IN_VALID(IN_VALID), .IN_READY(in_ready_t),
        .OUT(out_t), .OUT_VALID(out_valid_t), .OUT_READY(OUT_READY),
`ifdef MERGE22_PARITY_EN
        .OUT_PAR(out_par_t),
`endif
        .OVF(ovf_t), .OVF_CLR(OVF_CLR)
    );

    merge22_buf #(.OUT_W(16), .SATURATE(1)) dut_sat (
        .CLK(CLK), .RESET(RESET),
        .D0(d[0]),   .D1(d[1]),   .D2(d[2]),   .D3(d[3]),   .D4(d[4]),   .D5(d[5]),
        .D6(d[6]),   .D7(d[7]),   .D8(d[8]),   .D9(d[9]),   .D10(d[10]), .D11(d[11]),
        .D12(d[12]), .D13(d[13]), .D14(d[14]), .D15(d[15]), .D16(d[16]), .D17(d[17]),
        .D18(d[18]), .D19(d[19]), .D20(d[20]), .D21(d[21]),
        .IN_VALID(IN_VALID), .IN_READY(in_ready_s),
        .OUT(out_s), .OUT_VALID(out_valid_s), .OUT_READY(OUT_READY),
`ifdef MERGE22_PARITY_EN
        .OUT_PAR(out_par_s),
`endif
        .OVF(ovf_s), .OVF_CLR(OVF_CLR)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET     = 1'b1;
        d         = '0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        OVF_CLR   = 1'b0;

        // Reset cycle
        step();
        check("rst_in_ready", in_ready_t, 0);
        check("rst_out_valid", out_valid_t, 0);
        check("rst_out", out_t, 0);
        check("rst_ovf", ovf_t, 0);
        RESET = 1'b0;
        step();
        check("post_rst_in_ready", in_ready_t, 1);
        check("post_rst_out", out_t, 0);

        // Single word, one-cycle latency
        d = 22'h00A5C3; IN_VALID = 1'b1; OUT_READY = 1'b1;
        step();
        IN_VALID = 1'b0;
        check("single_valid", out_valid_t, 1);
        check("single_out", out_t, 16'hA5C3);
        check("single_out_sat", out_s, 16'hA5C3);
        check("single_ovf", ovf_t, 0);
`ifdef MERGE22_PARITY_EN
        check("single_par", out_par_t, 0);
`endif
        step();
        check("single_drained", out_valid_t, 0);
        check("single_drained_out", out_t, 0);

        // Backpressure fill
        OUT_READY = 1'b0; IN_VALID = 1'b1; d = 22'h1;
        step();
        check("bp_first_out", out_t, 16'h0001);
        check("bp_first_ready", in_ready_t, 1);
        d = 22'h2;
        step();
        check("bp_full_ready", in_ready_t, 0);
        check("bp_full_out", out_t, 16'h0001);
        d = 22'h3;
        step();
        check("bp_held_ready", in_ready_t, 0);
        check("bp_held_out", out_t, 16'h0001);
        OUT_READY = 1'b1;
        step();
        check("bp_drain2", out_t, 16'h0002);
        check("bp_reopen_ready", in_ready_t, 1);
        step();
        check("bp_drain3", out_t, 16'h0003);
        check("bp_drain3_valid", out_valid_t, 1);
        IN_VALID = 1'b0;
        step();
        check("bp_empty", out_valid_t, 0);

        // Simultaneous accept and release at count=1
        OUT_READY = 1'b0; IN_VALID = 1'b1; d = 22'h0F;
        step();
        check("sim_preload", out_t, 16'h000F);
        OUT_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d = 22'(8'h10 + k);
            step();
            check("sim_out", out_t, 32'(8'h10 + k));
            check("sim_valid", out_valid_t, 1);
            check("sim_ready", in_ready_t, 1);
        end
        IN_VALID = 1'b0;
        step();
        check("sim_empty", out_valid_t, 0);

        // Overflow: truncate vs saturate, sticky flag
        OUT_READY = 1'b0; IN_VALID = 1'b1; d = 22'h011234;
        step();
        IN_VALID = 1'b0;
        check("ovf_trunc_out", out_t, 16'h1234);
        check("ovf_trunc_flag", ovf_t, 1);
        check("ovf_sat_out", out_s, 16'hFFFF);
        check("ovf_sat_flag", ovf_s, 1);
`ifdef MERGE22_PARITY_EN
        check("ovf_sat_par", out_par_s, 0);
`endif
        step();
        check("ovf_held", ovf_t, 1);
        d = 22'h200001; IN_VALID = 1'b1; OVF_CLR = 1'b1; OUT_READY = 1'b1;
        step();
        IN_VALID = 1'b0;
        check("ovf_set_wins", ovf_t, 1);
        check("ovf_d21_trunc", out_t, 16'h0001);
        check("ovf_d21_sat", out_s, 16'hFFFF);
        step();
        OVF_CLR = 1'b0;
        check("ovf_cleared", ovf_t, 0);
        check("ovf_cleared_sat", ovf_s, 0);
        check("ovf_drained", out_valid_t, 0);

        // Reset mid-operation with a full FIFO
        OUT_READY = 1'b0; IN_VALID = 1'b1; d = 22'h000007;
        step();
        d = 22'h010008;
        step();
        IN_VALID = 1'b0;
        check("mid_full_ready", in_ready_t, 0);
        check("mid_head", out_t, 16'h0007);
        check("mid_ovf", ovf_t, 1);
`ifdef MERGE22_PARITY_EN
        check("mid_par", out_par_t, 1);
`endif
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("mid_rst_valid", out_valid_t, 0);
        check("mid_rst_out", out_t, 0);
        check("mid_rst_ovf", ovf_t, 0);
        check("mid_rst_ready", in_ready_t, 0);
`ifdef MERGE22_PARITY_EN
        check("mid_rst_par", out_par_t, 0);
`endif
        step();
        check("mid_post_ready", in_ready_t, 1);
        check("mid_post_valid", out_valid_t, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
